// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32 control FSM with memory wait timeout and sticky fault
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       isALUreg,
  input  logic       isALUimm,
  input  logic       isLoad,
  input  logic       isStore,
  input  logic       isJAL,
  input  logic       isJALR,
  input  logic       isBranch,
  input  logic       isLUI,
  input  logic       isAUIPC,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [3:0] state,
  output logic       fault,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [8:0] wait_inc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;
  assign fault = (state_q == S_FAULT);

  // Counter only advances in the three memory-waiting states, so it is zero on entry to each.
  always_comb begin
    state_d    = state_q;
    wait_d     = 8'd0;
    wait_inc   = {1'b0, wait_q} + 9'd1;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          wait_d = wait_inc[7:0];
          if (wait_inc >= TIMEOUT_LIM) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (isLoad || isStore) state_d = S_MEMADR;
        else if (isALUreg)     state_d = S_EXEC_R;
        else if (isALUimm)     state_d = S_EXEC_I;
        else if (isJAL)        state_d = S_JAL;
        else if (isJALR)       state_d = S_JALR;
        else if (isBranch)     state_d = S_BRANCH;
        else if (isLUI)        state_d = S_LUI;
        else if (isAUIPC)      state_d = S_AUIPC;
        else                   state_d = S_FAULT;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = isLoad ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          wait_d = wait_inc[7:0];
          if (wait_inc >= TIMEOUT_LIM) state_d = S_FAULT;
        end
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          wait_d = wait_inc[7:0];
          if (wait_inc >= TIMEOUT_LIM) state_d = S_FAULT;
        end
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a  = (state_q == S_JALR) ? 2'b10 : 2'b01;
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
        result_src = 2'b10;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = branch_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI, S_AUIPC: begin
        alu_src_a  = (state_q == S_AUIPC) ? 2'b01 : 2'b00;
        alu_src_b  = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] flags = 9'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, fault, instr_done;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;

  logic       mem_req4, mem_we4, adr_src4, ir_write4, pc_write4, reg_write4, fault4, instr_done4;
  logic [1:0] alu_src_a4, alu_src_b4, alu_op4, result_src4;
  logic [3:0] state4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .resetn(resetn),
    .isALUreg(flags[0]), .isALUimm(flags[1]), .isLoad(flags[2]), .isStore(flags[3]),
    .isJAL(flags[4]), .isJALR(flags[5]), .isBranch(flags[6]), .isLUI(flags[7]), .isAUIPC(flags[8]),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .state(state), .fault(fault), .instr_done(instr_done)
  );

  multicycle_controller #(.MEM_TIMEOUT(4)) dut4 (
    .clk(clk), .resetn(resetn),
    .isALUreg(flags[0]), .isALUimm(flags[1]), .isLoad(flags[2]), .isStore(flags[3]),
    .isJAL(flags[4]), .isJALR(flags[5]), .isBranch(flags[6]), .isLUI(flags[7]), .isAUIPC(flags[8]),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req4), .mem_we(mem_we4), .adr_src(adr_src4), .ir_write(ir_write4),
    .pc_write(pc_write4), .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_op(alu_op4), .result_src(result_src4), .state(state4), .fault(fault4), .instr_done(instr_done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    flags = 9'd0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL reset_state: state=%0d fault=%b want state=0 fault=0", state, fault);
    end
    total++;
    if (mem_req !== 1'b1 || pc_write !== 1'b0 || reg_write !== 1'b0 || instr_done !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: mem_req=%b pc_write=%b reg_write=%b done=%b want 1 0 0 0",
                      mem_req, pc_write, reg_write, instr_done);
    end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_alu_reg();
    logic [3:0] exp_s [8] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 4'd1, 4'd6, 4'd8};
    int done_cnt = 0;
    do_reset();
    flags = 9'b000000001;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (state !== exp_s[i] || reg_write !== (exp_s[i] == 4'd8)) begin
        bad++; $display("FAIL alu_reg_seq[%0d]: state=%0d reg_write=%b want state=%0d reg_write=%b",
                        i, state, reg_write, exp_s[i], exp_s[i] == 4'd8);
      end
      if (exp_s[i] == 4'd0) begin
        total++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b10) begin
          bad++; $display("FAIL fetch_outputs: ir_write=%b pc_write=%b alu_src_b=%b want 1 1 10",
                          ir_write, pc_write, alu_src_b);
        end
      end
      if (exp_s[i] == 4'd6) begin
        total++;
        if (alu_src_a !== 2'b10 || alu_src_b !== 2'b00 || alu_op !== 2'b10) begin
          bad++; $display("FAIL exec_r_outputs: a=%b b=%b op=%b want 10 00 10", alu_src_a, alu_src_b, alu_op);
        end
      end
      if (instr_done === 1'b1) done_cnt++;
      tick();
    end
    total++;
    if (done_cnt != 2) begin
      bad++; $display("FAIL alu_reg_done_count: got=%0d want=2", done_cnt);
    end
  endtask

  task automatic test_load_stall();
    logic [3:0] exp_s [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rdy   [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    flags = 9'b000000100;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (state !== exp_s[i]) begin
        bad++; $display("FAIL load_seq[%0d]: state=%0d want=%0d", i, state, exp_s[i]);
      end
      if (exp_s[i] == 4'd3) begin
        total++;
        if (mem_req !== 1'b1 || adr_src !== 1'b1 || mem_we !== 1'b0) begin
          bad++; $display("FAIL memread_outputs[%0d]: mem_req=%b adr_src=%b mem_we=%b want 1 1 0",
                          i, mem_req, adr_src, mem_we);
        end
      end
      if (exp_s[i] == 4'd4) begin
        total++;
        if (result_src !== 2'b01 || reg_write !== 1'b1 || instr_done !== 1'b1) begin
          bad++; $display("FAIL memwb_outputs: result_src=%b reg_write=%b done=%b want 01 1 1",
                          result_src, reg_write, instr_done);
        end
      end
      tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    flags = 9'b001000000;
    mem_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      branch_taken = (t == 1);
      tick();
      tick();
      #1;
      total++;
      if (state !== 4'd11 || pc_write !== (t == 1) || reg_write !== 1'b0 ||
          instr_done !== 1'b1 || alu_op !== 2'b01) begin
        bad++; $display("FAIL branch_taken_%0d: state=%0d pc_write=%b reg_write=%b done=%b op=%b want 11 %0d 0 1 01",
                        t, state, pc_write, reg_write, instr_done, alu_op, t);
      end
      tick();
    end
  endtask

  task automatic test_no_flag_fault();
    int sticky_bad = 0;
    do_reset();
    mem_ready = 1'b1;
    tick();
    tick();
    total++;
    if (state !== 4'd15 || fault !== 1'b1) begin
      bad++; $display("FAIL no_flag_fault: state=%0d fault=%b want 15 1", state, fault);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      flags = 9'(1 << (i % 9));
      #1;
      if (state !== 4'd15 || fault !== 1'b1 || mem_req !== 1'b0 || ir_write !== 1'b0 ||
          pc_write !== 1'b0 || reg_write !== 1'b0 || instr_done !== 1'b0) sticky_bad++;
      tick();
    end
    total++;
    if (sticky_bad != 0) begin
      bad++; $display("FAIL fault_sticky: bad_cycles=%0d want 0", sticky_bad);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL fault_clear: state=%0d fault=%b want 0 0", state, fault);
    end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_timeout();
    int irw = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (ir_write4 !== 1'b0) irw++;
      tick();
    end
    total++;
    if (state4 !== 4'd15 || fault4 !== 1'b1 || irw != 0) begin
      bad++; $display("FAIL timeout4: state=%0d fault=%b ir_writes=%0d want 15 1 0", state4, fault4, irw);
    end
    total++;
    if (state !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL timeout15_early: state=%0d fault=%b want 0 0", state, fault);
    end
    for (int i = 4; i < 14; i++) tick();
    total++;
    if (state !== 4'd0) begin
      bad++; $display("FAIL timeout15_edge14: state=%0d want 0", state);
    end
    tick();
    total++;
    if (state !== 4'd15 || fault !== 1'b1 || ir_write !== 1'b0) begin
      bad++; $display("FAIL timeout15_edge15: state=%0d fault=%b ir_write=%b want 15 1 0", state, fault, ir_write);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    flags = 9'b000001000;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    total++;
    if (state !== 4'd5 || mem_we !== 1'b1 || mem_req !== 1'b1 || adr_src !== 1'b1 || instr_done !== 1'b0) begin
      bad++; $display("FAIL memwrite_outputs: state=%0d we=%b req=%b adr=%b done=%b want 5 1 1 1 0",
                      state, mem_we, mem_req, adr_src, instr_done);
    end
    tick();
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || mem_we !== 1'b0 || instr_done !== 1'b0 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
      bad++; $display("FAIL reset_mid_write: state=%0d we=%b done=%b rw=%b pw=%b want 0 0 0 0 0",
                      state, mem_we, instr_done, reg_write, pc_write);
    end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [8:0] f  [7] = '{9'b000000010, 9'b000010000, 9'b000100000, 9'b010000000,
                           9'b100000000, 9'b000000101, 9'b000010001};
    int         n  [7] = '{2, 1, 1, 1, 1, 3, 2};
    logic [3:0] s1 [7] = '{4'd7, 4'd9, 4'd10, 4'd12, 4'd13, 4'd2, 4'd6};
    logic [3:0] sl [7] = '{4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd4, 4'd8};
    logic [1:0] rs [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] sa [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    logic [1:0] sb [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic       pw [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      flags = f[i];
      tick();
      tick();
      total++;
      if (state !== s1[i]) begin
        bad++; $display("FAIL b2b_dispatch[%0d]: state=%0d want=%0d", i, state, s1[i]);
      end
      for (int k = 1; k < n[i]; k++) tick();
      flags = 9'd0;
      #1;
      total++;
      if (state !== sl[i] || reg_write !== 1'b1 || instr_done !== 1'b1 || pc_write !== pw[i] ||
          result_src !== rs[i] || alu_src_a !== sa[i] || alu_src_b !== sb[i]) begin
        bad++; $display("FAIL b2b_last[%0d]: state=%0d rw=%b done=%b pw=%b rs=%b a=%b b=%b want %0d 1 1 %b %b %b %b",
                        i, state, reg_write, instr_done, pc_write, result_src, alu_src_a, alu_src_b,
                        sl[i], pw[i], rs[i], sa[i], sb[i]);
      end
      tick();
      total++;
      if (state !== 4'd0) begin
        bad++; $display("FAIL b2b_return[%0d]: state=%0d want=0", i, state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_reg();
    test_load_stall();
    test_branch();
    test_no_flag_fault();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
